// File: rtl/mux_pkg.sv
// Shared types and helpers for the pipelined N:1 selector.
// Skid-buffer state encoding and select-width helper.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_st_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nt1_pipe_skid_buf2.sv
// Two-entry skid buffer: main register feeds the output, skid absorbs
// the beat accepted while the consumer stalls.
module skid_buf2
  import mux_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [PW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [PW-1:0] out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i
);

  skid_st_e      state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          rdy_q;
  logic          acc, dlv;

  assign acc = in_valid_i & rdy_q;
  assign dlv = (state_q != EMPTY) & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          main_d  = in_data_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (acc && dlv) begin
          main_d = in_data_i;
        end else if (acc) begin
          skid_d  = in_data_i;
          state_d = FULL;
        end else if (dlv) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (dlv) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != FULL);
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_data_o  = main_q;
  assign out_valid_o = (state_q != EMPTY);

endmodule

// File: rtl/mux_nt1_pipe.sv
// Pipelined N:1 selector with range check, optional packet lock
// and a skid-buffered valid/ready output stage.
module mux_nt1_pipe
  import mux_pkg::*;
#(
  parameter int N        = 2,
  parameter int W        = 5,
  parameter int SW       = clog2_min1(N),
  parameter bit LOCK_SEL = 1'b0
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N*W-1:0] IN_DATA,
  input  logic [SW-1:0]  IN_SEL,
  input  logic           IN_VALID,
  input  logic           IN_LAST,
  output logic           IN_READY,
  output logic [W-1:0]   OUT_DATA,
  output logic [SW-1:0]  OUT_SEL,
  output logic           OUT_ERR,
  output logic           OUT_VALID,
  input  logic           OUT_READY
);

  localparam int PW = W + SW + 1;
  localparam logic [SW:0] NMAX = (SW+1)'(N);

  logic          lock_q, lock_d;
  logic [SW-1:0] lsel_q, lsel_d;
  logic [SW-1:0] eff_sel;
  logic [W-1:0]  sel_data;
  logic          sel_err;
  logic          acc;
  logic [PW-1:0] pl_in, pl_out;

  assign acc = IN_VALID & IN_READY;
  assign eff_sel = (LOCK_SEL && lock_q) ? lsel_q : IN_SEL;
  assign sel_err = ({1'b0, eff_sel} >= NMAX);

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (!sel_err && eff_sel == SW'(k)) begin
        sel_data = IN_DATA[k*W +: W];
      end
    end
  end

  // Single-beat packets never take the lock.
  always_comb begin
    lock_d = lock_q;
    lsel_d = lsel_q;
    if (LOCK_SEL && acc) begin
      if (IN_LAST) begin
        lock_d = 1'b0;
      end else if (!lock_q) begin
        lock_d = 1'b1;
        lsel_d = IN_SEL;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_q <= 1'b0;
      lsel_q <= '0;
    end else begin
      lock_q <= lock_d;
      lsel_q <= lsel_d;
    end
  end

  assign pl_in = {sel_err, eff_sel, sel_data};

  skid_buf2 #(.PW(PW)) u_skid (
    .clk_i       (CLK),
    .rst_i       (RST),
    .in_data_i   (pl_in),
    .in_valid_i  (IN_VALID),
    .in_ready_o  (IN_READY),
    .out_data_o  (pl_out),
    .out_valid_o (OUT_VALID),
    .out_ready_i (OUT_READY)
  );

  assign OUT_ERR  = pl_out[PW-1];
  assign OUT_SEL  = pl_out[W +: SW];
  assign OUT_DATA = pl_out[W-1:0];

endmodule

// File: doc/mux_nt1_pipe.md
Name: mux_nt1_pipe

Overview:
- Parametrised N-to-1, W-bit select multiplexer with a registered output stage and a valid/ready handshake.
- Generalises the datapath 2:1 selectors (register-destination, ALU-source) into one reusable pipelined selector.
- Optional packet-lock mode holds the select for a multi-beat transfer.
- Sits between pipeline stages wherever a selected operand must cross a stall boundary.

Parameters:
- N, 2, number of input channels (2..16).
- W, 5, data width per channel (1..64).
- SW, $clog2(N) (minimum 1), select width.
- LOCK_SEL, 0: 1 = select captured on the first beat of a packet and held until the IN_LAST beat is accepted.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_DATA  in  N*W  packed channels; channel k occupies bits [k*W +: W].
- IN_SEL  in  SW  channel select.
- IN_VALID  in  1  input beat valid.
- IN_LAST  in  1  last beat of a packet; ignored when LOCK_SEL=0.
- IN_READY  out  1  block can accept a beat; driven from a register.
- OUT_DATA  out  W  selected data, registered.
- OUT_SEL  out  SW  select used for this beat.
- OUT_ERR  out  1  select was out of range (IN_SEL >= N); OUT_DATA = 0 for that beat.
- OUT_VALID  out  1  output beat valid.
- OUT_READY  in  1  consumer accepts.

Behaviour:
- Transfer rules: a beat is accepted when IN_VALID & IN_READY. A beat is delivered when OUT_VALID & OUT_READY.
- Reset values (RST high at an edge): OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, OUT_ERR=0, IN_READY=1, lock released, buffer EMPTY. RST overrides all handshakes, including an in-flight beat, which is dropped.
- Latency: an accepted beat appears on OUT_* on the next cycle. Throughput is 1 beat/cycle while OUT_READY=1.
- Buffer is a 2-entry skid buffer (main register plus skid register).
- State EMPTY:
  - accept -> ONE.
- State ONE:
  - accept & deliver -> ONE.
  - accept & !deliver -> FULL (beat goes to skid).
  - deliver & !accept -> EMPTY.
- State FULL:
  - IN_READY=0.
  - deliver -> ONE; skid moves to main the same edge.
- IN_READY is asserted in EMPTY and ONE.
- The combinational path IN_* -> IN_READY is forbidden; IN_READY depends only on state.
- Holding rule: while OUT_VALID=1 and OUT_READY=0, OUT_DATA, OUT_SEL and OUT_ERR must not change.
- Select resolution (captured with the data at accept):
  - eff_sel = IN_SEL, except when LOCK_SEL=1 and locked, then eff_sel = locked_sel.
  - eff_sel >= N gives data 0 and ERR=1.
- Lock (LOCK_SEL=1 only):
  - An accepted beat with lock released captures locked_sel = IN_SEL and sets locked, unless IN_LAST=1 (a single-beat packet leaves the lock released).
  - An accepted beat with IN_LAST=1 releases the lock after that beat.
  - IN_SEL changes while locked are ignored.
  - An out-of-range captured select stays locked and flags ERR on every beat of the packet.
- Input data is not registered before the select; only the mux output is stored.
- N not a power of two: codes N..2^SW-1 are out of range.

Decomposition:
- Shared package mux_pkg:
  - skid state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2);
  - function clog2_min1.
- Natural sub-module skid_buf2 (W+SW+1-bit payload, valid/ready both sides), reused for other pipeline boundaries.
- The N-way select/range check stays inline.

Test Plan:
- N=2, W=5, IN_DATA={5'b00001,5'b00000}, IN_VALID=1, OUT_READY=1, IN_SEL toggling each cycle -> OUT_DATA 0,1,0,1 one cycle later; OUT_ERR=0; IN_READY constantly 1.
- N=4, W=8, back-to-back beats sel 0..3, OUT_READY low for 2 cycles mid-stream -> FULL reached, IN_READY=0 one cycle later; outputs held stable; no beat lost or duplicated; order preserved after release.
- N=3, IN_SEL=3 -> OUT_DATA=0, OUT_ERR=1, OUT_SEL=3; following beat with sel 2 -> OUT_ERR=0.
- LOCK_SEL=1, N=4, 4-beat packet with IN_SEL 1,3,0,2 and IN_LAST on beat 4 -> all four outputs from channel 1. Next packet with IN_SEL=2 selects channel 2.
- LOCK_SEL=1, single beat with IN_LAST=1 and sel 3, then beat sel 0 -> channel 3 then channel 0.
- RST asserted for 1 cycle while FULL with OUT_READY=0 -> next cycle OUT_VALID=0, IN_READY=1, lock released; subsequent beat passes normally.
